// File: rtl/decoder_scan_n.sv
// decoder_scan_n: registered one-hot decoder with a divided walking-one scan mode
module decoder_scan_n #(
    parameter int N_SEL      = 3,
    parameter int SCAN_DIV   = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  sel_valid,
    input  logic [N_SEL-1:0]      sel,
    output logic                  sel_ready,
    output logic [2**N_SEL-1:0]   out_line,
    output logic                  out_valid,
    output logic                  scan_wrap
);
    localparam int W  = 2**N_SEL;
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, DEC, SCAN} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    line, line_nx;
    logic [DW-1:0]   div, div_nx;
    logic            valid_nx, wrap_nx;

    assign sel_ready = rst_n && !mode && state != SCAN;
    assign out_line  = ACTIVE_LOW ? ~line : line;

    always_comb begin
        state_nx = state;
        line_nx  = line;
        div_nx   = div;
        valid_nx = 1'b0;
        wrap_nx  = 1'b0;
        if (state != SCAN) begin
            if (mode) begin
                state_nx = SCAN;
                line_nx  = W'(1);
                div_nx   = '0;
                valid_nx = 1'b1;
            end else if (sel_valid && sel_ready) begin
                state_nx = DEC;
                line_nx  = W'(1) << sel;
                valid_nx = 1'b1;
            end
        end else if (!mode) begin
            state_nx = IDLE;
            line_nx  = '0;
            div_nx   = '0;
            valid_nx = 1'b1;
        end else if (div == DIV_LAST) begin
            line_nx  = {line[W-2:0], line[W-1]};
            div_nx   = '0;
            valid_nx = 1'b1;
            wrap_nx  = line[W-1];
        end else begin
            div_nx   = div + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            line      <= '0;
            div       <= '0;
            out_valid <= 1'b0;
            scan_wrap <= 1'b0;
        end else begin
            state     <= state_nx;
            line      <= line_nx;
            div       <= div_nx;
            out_valid <= valid_nx;
            scan_wrap <= wrap_nx;
        end
    end
endmodule

// File: tb/tb_decoder_scan_n.sv
// tb_decoder_scan_n: table and scoreboard checks for decode, scan, mode drop and reset
module tb_decoder_scan_n;
    logic       clk = 1'b0;
    logic       rst_n, mode, sel_valid;
    logic [2:0] sel;
    logic       u0_ready, u0_ov, u0_wrap;
    logic [7:0] u0_line;
    logic       u1_ready, u1_ov, u1_wrap;
    logic [7:0] u1_line;
    logic       u2_ready, u2_ov, u2_wrap;
    logic [1:0] u2_line;
    int         checks = 0;
    int         failures = 0;

    typedef struct {
        logic       m, v;
        logic [2:0] s;
        logic       rdy;
        logic [7:0] line;
        logic       ov, wrap;
    } vec_t;

    typedef struct {
        logic [7:0] line;
        logic       ov, wrap;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[12];

    always #5 clk = ~clk;

    decoder_scan_n u0 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel_valid(sel_valid), .sel(sel),
        .sel_ready(u0_ready), .out_line(u0_line), .out_valid(u0_ov), .scan_wrap(u0_wrap)
    );

    decoder_scan_n #(.ACTIVE_LOW(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel_valid(sel_valid), .sel(sel),
        .sel_ready(u1_ready), .out_line(u1_line), .out_valid(u1_ov), .scan_wrap(u1_wrap)
    );

    decoder_scan_n #(.N_SEL(1), .SCAN_DIV(1)) u2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel_valid(sel_valid), .sel(sel[0]),
        .sel_ready(u2_ready), .out_line(u2_line), .out_valid(u2_ov), .scan_wrap(u2_wrap)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic m, input logic v, input logic [2:0] s, input logic rdy,
                       input logic [7:0] el, input logic eo, input logic ew);
        exp_t e;
        mode = m;
        sel_valid = v;
        sel = s;
        #1;
        chk("sel_ready", 8'(u0_ready), 8'(rdy));
        sb.push_back('{el, eo, ew});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("out_line", u0_line, e.line);
        chk("out_valid", 8'(u0_ov), 8'(e.ov));
        chk("scan_wrap", 8'(u0_wrap), 8'(e.wrap));
        chk("out_line_active_low", u1_line, ~e.line);
        chk("out_valid_active_low", 8'(u1_ov), 8'(e.ov));
    endtask

    task automatic scan_run(input int k0, input int k1, output int wraps);
        logic [7:0] one;
        int         ph;
        logic       st, w;
        one = 8'h01;
        wraps = 0;
        for (int k = k0; k < k1; k++) begin
            ph = (k / 4) % 8;
            st = (k % 4 == 0);
            w  = st && ph == 0 && k != 0;
            wraps += int'(w);
            cyc(1'b1, 1'b1, 3'd6, 1'b0, one << ph, st, w);
        end
    endtask

    initial begin
        int wraps;
        tbl[0]  = '{1'b0, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 3'd1, 1'b1, 8'h02, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 3'd2, 1'b1, 8'h04, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 3'd3, 1'b1, 8'h08, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 3'd4, 1'b1, 8'h10, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3'd5, 1'b1, 8'h20, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 3'd6, 1'b1, 8'h40, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 3'd7, 1'b1, 8'h80, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 3'd0, 1'b1, 8'h80, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 3'd2, 1'b0, 8'h01, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 3'd5, 1'b1, 8'h20, 1'b1, 1'b0};

        rst_n = 1'b0;
        mode = 1'b1;
        sel_valid = 1'b1;
        sel = 3'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 8'(u0_ready), 8'h00);
        chk("reset_line", u0_line, 8'h00);
        chk("reset_valid", 8'(u0_ov), 8'h00);
        chk("reset_wrap", 8'(u0_wrap), 8'h00);
        chk("reset_line_active_low", u1_line, 8'hff);

        rst_n = 1'b1;
        for (int i = 0; i < 12; i++)
            cyc(tbl[i].m, tbl[i].v, tbl[i].s, tbl[i].rdy, tbl[i].line, tbl[i].ov, tbl[i].wrap);

        scan_run(0, 40, wraps);
        chk("scan_wrap_count", 8'(wraps), 8'd1);
        scan_run(40, 48, wraps);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 3'd3, 1'b1, 8'h08, 1'b1, 1'b0);

        scan_run(0, 24, wraps);
        rst_n = 1'b0;
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        rst_n = 1'b1;
        mode = 1'b1;
        sel_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk);
            #1;
            chk("fast_scan_line", 8'(u2_line), (j == 0 || j % 2 == 0) ? 8'h01 : 8'h02);
            chk("fast_scan_valid", 8'(u2_ov), 8'h01);
            chk("fast_scan_wrap", 8'(u2_wrap), (j != 0 && j % 2 == 0) ? 8'h01 : 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
